// File: rtl/bcdparabin.sv
// rtl/bcdparabin.sv - sequential BCD-to-binary converter (reverse double-dabble), start/ready/done_tick handshake.
// Optional invalid-digit detection and err port enabled by defining BCDPARABIN_ERR_EN.
module bcdparabin #(
  parameter int N_DIG = 3,
  parameter int BIN_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*N_DIG-1:0] bcd,
  output logic               ready,
  output logic               done_tick,
  output logic [BIN_W-1:0]   bin
`ifdef BCDPARABIN_ERR_EN
  ,
  output logic               err
`endif
);

  localparam int BCD_W = 4 * N_DIG;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_OP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_reg_q, bin_reg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W+BIN_W-1:0] shift_w;
  logic [BCD_W-1:0]   bcd_corr;
`ifdef BCDPARABIN_ERR_EN
  logic               err_q, err_d;
  logic               bad_digit;
`endif

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_reg_d = bin_reg_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    ready     = (state_q == S_IDLE);
    done_tick = (state_q == S_DONE);

    // One right shift of the concatenation, then each digit that became >=8 drops by 3.
    shift_w  = {bcd_q, bin_reg_q} >> 1;
    bcd_corr = '0;
    for (int i = 0; i < N_DIG; i++) begin
      bcd_corr[4*i +: 4] = (shift_w[BIN_W+4*i +: 4] >= 4'd8) ?
                           shift_w[BIN_W+4*i +: 4] - 4'd3 :
                           shift_w[BIN_W+4*i +: 4];
    end

`ifdef BCDPARABIN_ERR_EN
    err_d     = err_q;
    bad_digit = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d     = bcd;
          bin_reg_d = '0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = S_OP;
`ifdef BCDPARABIN_ERR_EN
          err_d = 1'b0;
          if (bad_digit) begin
            state_d = S_DONE;
            bin_d   = '0;
            err_d   = 1'b1;
          end
`endif
        end
      end
      S_OP: begin
        bcd_d     = bcd_corr;
        bin_reg_d = shift_w[BIN_W-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          bin_d   = shift_w[BIN_W-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bcd_q     <= '0;
      bin_reg_q <= '0;
      cnt_q     <= '0;
      bin_q     <= '0;
`ifdef BCDPARABIN_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_reg_q <= bin_reg_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
`ifdef BCDPARABIN_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bin = bin_q;
`ifdef BCDPARABIN_ERR_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_bcdparabin.sv
// tb/tb_bcdparabin.sv - self-checking bench for bcdparabin against a decimal-arithmetic reference.
module tb_bcdparabin;

  localparam int N_DIG = 3;
  localparam int BIN_W = 10;
  localparam int LAT   = BIN_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [4*N_DIG-1:0] bcd_i;
  logic             ready;
  logic             done_tick;
  logic [BIN_W-1:0] bin;
`ifdef BCDPARABIN_ERR_EN
  logic             err;
`endif

  int checks = 0;
  int errors = 0;

  bcdparabin #(.N_DIG(N_DIG), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd(bcd_i),
    .ready(ready), .done_tick(done_tick), .bin(bin)
`ifdef BCDPARABIN_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  function automatic int ref_bin(input logic [4*N_DIG-1:0] v);
    int acc = 0;
    int w = 1;
    for (int i = 0; i < N_DIG; i++) begin
      acc = acc + w * int'(v[4*i +: 4]);
      w = w * 10;
    end
    return acc;
  endfunction

  function automatic logic [4*N_DIG-1:0] rand_bcd();
    logic [4*N_DIG-1:0] v;
    for (int i = 0; i < N_DIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Launch one conversion from IDLE; optionally inject an ignored start at OP cycle inject_k.
  task automatic do_conv(input logic [4*N_DIG-1:0] v, input int inject_k,
                         output int lat, output logic [BIN_W-1:0] res, output bit got);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL ready_at_start: got %b want 1", ready);
    end
    bcd_i = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcd_i = 12'($urandom);
    lat = 0; got = 0; res = '0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (done_tick === 1'b1) begin
        got = 1; lat = k; res = bin;
      end else if (k == 1) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++; $display("FAIL ready_in_op: got %b want 0", ready);
        end
      end
      if (inject_k != 0 && k == inject_k) begin start = 1'b1; bcd_i = 12'h111; end
      if (inject_k != 0 && k == inject_k + 1) start = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL done_timeout: got none want done_tick within 40 cycles");
    end
  endtask

  task automatic check_conv(input string name, input logic [4*N_DIG-1:0] v, input int inject_k);
    int lat; logic [BIN_W-1:0] res; bit got;
    do_conv(v, inject_k, lat, res, got);
    if (got) begin
      checks++;
      if (lat != LAT) begin
        errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
      end
      checks++;
      if (int'(res) != ref_bin(v)) begin
        errors++; $display("FAIL %s_bin: bcd %h got %0d want %0d", name, v, res, ref_bin(v));
      end
`ifdef BCDPARABIN_ERR_EN
      checks++;
      if (err !== 1'b0) begin
        errors++; $display("FAIL %s_err: got %b want 0", name, err);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; bcd_i = 12'h054;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || bin !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b done=%b bin=%0d want 1 0 0", ready, done_tick, bin);
    end
`ifdef BCDPARABIN_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
`endif
  endtask

  task automatic test_directed();
    check_conv("d054", 12'h054, 0);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0) begin
      errors++; $display("FAIL ready_after_done: got ready=%b done=%b want 1 0", ready, done_tick);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bin !== 10'h036) begin errors++; $display("FAIL bin_hold: got %0d want 54", bin); end
    check_conv("d999", 12'h999, 0);
    check_conv("d000", 12'h000, 0);
    check_conv("d255", 12'h255, 0);
  endtask

  task automatic test_ignored_start();
    check_conv("ign", 12'h987, 3);
  endtask

  task automatic test_reset_mid_op();
    bit seen = 0;
    @(negedge clk);
    bcd_i = 12'h054; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_tick === 1'b1) seen = 1;
    end
    checks++;
    if (seen || ready !== 1'b1 || bin !== '0) begin
      errors++;
      $display("FAIL reset_mid_op: got done_seen=%b ready=%b bin=%0d want 0 1 0", seen, ready, bin);
    end
    check_conv("after_rst", 12'h054, 0);
  endtask

  task automatic test_back_to_back_random();
    for (int n = 0; n < 20; n++) check_conv("rand", rand_bcd(), 0);
  endtask

`ifdef BCDPARABIN_ERR_EN
  task automatic test_err();
    int lat; logic [BIN_W-1:0] res; bit got;
    do_conv(12'h0A5, 0, lat, res, got);
    if (got) begin
      checks++;
      if (lat != 1 || err !== 1'b1 || res !== '0) begin
        errors++;
        $display("FAIL err_detect: got lat=%0d err=%b bin=%0d want 1 1 0", lat, err, res);
      end
    end
    check_conv("after_err", 12'h054, 0);
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; bcd_i = '0;
    test_reset();
    test_directed();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back_random();
`ifdef BCDPARABIN_ERR_EN
    test_err();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
